llc_mem_req_buf: RTL and testbench

LLC_MEM_REQ_BUF -- requirements
Module: llc_mem_req_buf

---
 rtl/llc_mem_req_buf.sv | 108 ++++++++++
 tb/tb_llc_mem_req_buf.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/llc_mem_req_buf.sv
// llc_mem_req_buf: in-order request buffer between the LLC and memory.
// Requests are held in a circular buffer. Reads issued to memory are
// counted, and a read at the head is held back while the outstanding-read
// limit is reached. Writes queued behind that read wait as well, so
// requests always leave in the order they arrived.
module llc_mem_req_buf #(
    parameter  int DEPTH  = 4,
    parameter  int MAX_RD = 2,
    parameter  int ADDR_W = 28,
    parameter  int LINE_W = 128,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1,
    localparam int RD_W   = $clog2(MAX_RD) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_hwrite,
    input  logic [2:0]        in_hsize,
    input  logic [1:0]        in_hprot,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [LINE_W-1:0] in_line,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_hwrite,
    output logic [2:0]        out_hsize,
    output logic [1:0]        out_hprot,
    output logic [ADDR_W-1:0] out_addr,
    output logic [LINE_W-1:0] out_line,
    input  logic              rsp_done,
    output logic [CNT_W-1:0]  count,
    output logic [RD_W-1:0]   rd_outstanding,
    output logic              err_underflow
);

    logic              mem_hwrite [DEPTH];
    logic [2:0]        mem_hsize  [DEPTH];
    logic [1:0]        mem_hprot  [DEPTH];
    logic [ADDR_W-1:0] mem_addr   [DEPTH];
    logic [LINE_W-1:0] mem_line   [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;
    logic             rd_pop;

    assign in_ready   = (count < CNT_W'(DEPTH));
    assign out_hwrite = mem_hwrite[rd_ptr];
    assign out_hsize  = mem_hsize[rd_ptr];
    assign out_hprot  = mem_hprot[rd_ptr];
    assign out_addr   = mem_addr[rd_ptr];
    assign out_line   = mem_line[rd_ptr];

    // The read gate looks only at the head entry, which keeps issue strictly in order.
    assign out_valid = (count != '0) & (out_hwrite | (rd_outstanding < RD_W'(MAX_RD)));

    assign push   = in_valid & in_ready;
    assign pop    = out_valid & out_ready;
    assign rd_pop = pop & ~out_hwrite;

    // Entry storage is not reset; the payload is only meaningful while out_valid is high.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_hwrite[wr_ptr] <= in_hwrite;
            mem_hsize[wr_ptr]  <= in_hsize;
            mem_hprot[wr_ptr]  <= in_hprot;
            mem_addr[wr_ptr]   <= in_addr;
            mem_line[wr_ptr]   <= in_line;
        end
    end

    // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Outstanding-read credit; a response with nothing outstanding is flagged, never wrapped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_outstanding <= '0;
            err_underflow  <= 1'b0;
        end else begin
            case ({rd_pop, rsp_done})
                2'b10: rd_outstanding <= rd_outstanding + RD_W'(1);
                2'b01: begin
                    if (rd_outstanding == '0) err_underflow  <= 1'b1;
                    else                      rd_outstanding <= rd_outstanding - RD_W'(1);
                end
                default: rd_outstanding <= rd_outstanding;
            endcase
        end
    end

endmodule

// File: tb/tb_llc_mem_req_buf.sv
// Testbench for llc_mem_req_buf: directed scenarios followed by a random
// phase, all checked against a queue-based reference model.
module tb_llc_mem_req_buf;

    localparam int DEPTH  = 4;
    localparam int MAX_RD = 2;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         in_hwrite;
    logic [2:0]   in_hsize;
    logic [1:0]   in_hprot;
    logic [27:0]  in_addr;
    logic [127:0] in_line;
    logic         out_valid;
    logic         out_ready;
    logic         out_hwrite;
    logic [2:0]   out_hsize;
    logic [1:0]   out_hprot;
    logic [27:0]  out_addr;
    logic [127:0] out_line;
    logic         rsp_done;
    logic [2:0]   count;
    logic [1:0]   rd_outstanding;
    logic         err_underflow;

    llc_mem_req_buf dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_hwrite(in_hwrite),
        .in_hsize(in_hsize), .in_hprot(in_hprot), .in_addr(in_addr), .in_line(in_line),
        .out_valid(out_valid), .out_ready(out_ready), .out_hwrite(out_hwrite),
        .out_hsize(out_hsize), .out_hprot(out_hprot), .out_addr(out_addr), .out_line(out_line),
        .rsp_done(rsp_done), .count(count), .rd_outstanding(rd_outstanding),
        .err_underflow(err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         hw;
        logic [2:0]   sz;
        logic [1:0]   pr;
        logic [27:0]  addr;
        logic [127:0] line;
    } ent_t;

    ent_t q[$];
    int   m_rd;
    bit   m_err;
    int   n_chk;
    int   n_fail;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input bit v, input bit hw, input logic [27:0] a);
        in_valid  = v;
        in_hwrite = hw;
        in_addr   = a;
        in_hsize  = 3'($urandom);
        in_hprot  = 2'($urandom);
        in_line   = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Compare all outputs against the model, then advance model and DUT one cycle.
    task automatic tick();
        bit   e_ir, e_ov, push, pop, rd_pop;
        ent_t e;
        e_ir = (q.size() < DEPTH);
        e_ov = 1'b0;
        if (q.size() != 0) e_ov = q[0].hw || (m_rd < MAX_RD);
        check("in_ready", in_ready, e_ir);
        check("out_valid", out_valid, e_ov);
        check("count", count, q.size());
        check("rd_outstanding", rd_outstanding, m_rd);
        check("err_underflow", err_underflow, m_err);
        if (e_ov) begin
            check("out_hwrite", out_hwrite, q[0].hw);
            check("out_hsize", out_hsize, q[0].sz);
            check("out_hprot", out_hprot, q[0].pr);
            check("out_addr", out_addr, q[0].addr);
            check("out_line", out_line, q[0].line);
        end
        push   = in_valid && e_ir;
        pop    = e_ov && out_ready;
        rd_pop = pop && !q[0].hw;
        if (pop) void'(q.pop_front());
        if (push) begin
            e.hw = in_hwrite; e.sz = in_hsize; e.pr = in_hprot;
            e.addr = in_addr; e.line = in_line;
            q.push_back(e);
        end
        if (rd_pop && !rsp_done) m_rd++;
        else if (!rd_pop && rsp_done) begin
            if (m_rd == 0) m_err = 1'b1;
            else           m_rd--;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Raise reset, confirm the asynchronous clear before any clock edge, then release.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_count", count, 0);
        check("rst_rd_outstanding", rd_outstanding, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_err", err_underflow, 0);
        q.delete();
        m_rd  = 0;
        m_err = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        n_chk = 0; n_fail = 0; m_rd = 0; m_err = 1'b0;
        rst = 1'b1; out_ready = 1'b0; rsp_done = 1'b0;
        set_in(1'b0, 1'b0, 28'h0);
        do_reset();

        // Fill with writes while memory stalls, then drain in order.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 1'b1, 28'h10 + 28'(i));
            tick();
        end
        set_in(1'b0, 1'b0, 28'h0);
        check("fill_count", count, 4);
        check("fill_in_ready", in_ready, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_addr", out_addr, 28'h10 + 28'(i));
            tick();
        end
        check("drain_count", count, 0);

        // Read limit: third read waits for a response.
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 1'b0, 28'h20 + 28'(i));
            tick();
        end
        set_in(1'b0, 1'b0, 28'h0);
        tick();
        check("rdlim_outstanding", rd_outstanding, 2);
        check("rdlim_out_valid", out_valid, 0);
        check("rdlim_count", count, 1);
        rsp_done = 1'b1;
        tick();
        rsp_done = 1'b0;
        check("rdlim_release", out_valid, 1);
        check("rdlim_addr", out_addr, 28'h22);
        tick();
        rsp_done = 1'b1;
        tick();
        tick();
        rsp_done = 1'b0;
        check("rdlim_drained", rd_outstanding, 0);

        // Simultaneous push and pop with two entries resident; pointers wrap.
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_in(1'b1, 1'b1, 28'h30 + 28'(i));
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, 1'b1, 28'h40 + 28'(i));
            check("pp_count", count, 2);
            tick();
        end
        set_in(1'b0, 1'b0, 28'h0);
        tick();
        tick();
        check("pp_drained", count, 0);

        // Read issue and response in the same cycle.
        set_in(1'b1, 1'b0, 28'h50);
        tick();
        set_in(1'b1, 1'b0, 28'h51);
        tick();
        set_in(1'b0, 1'b0, 28'h0);
        rsp_done = 1'b1;
        check("same_pre_rd", rd_outstanding, 1);
        check("same_pre_ov", out_valid, 1);
        tick();
        check("same_post_rd", rd_outstanding, 1);
        tick();
        rsp_done = 1'b0;
        check("same_cleared", rd_outstanding, 0);

        // Underflow is sticky.
        rsp_done = 1'b1;
        tick();
        rsp_done = 1'b0;
        check("uf_set", err_underflow, 1);
        check("uf_rd_zero", rd_outstanding, 0);
        for (int i = 0; i < 3; i++) tick();
        check("uf_held", err_underflow, 1);

        // Reset in the middle of traffic with count = 3, rd_outstanding = 2.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, 1'b0, 28'h60 + 28'(i));
            tick();
        end
        set_in(1'b0, 1'b0, 28'h0);
        check("mid_count", count, 3);
        check("mid_rd", rd_outstanding, 2);
        do_reset();
        rsp_done = 1'b1;
        tick();
        rsp_done = 1'b0;
        check("stale_rsp_err", err_underflow, 1);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            set_in($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, 28'($urandom));
            out_ready = ($urandom_range(0, 3) != 0);
            if (m_rd > 0) rsp_done = ($urandom_range(0, 2) == 0);
            else          rsp_done = ($urandom_range(0, 60) == 0);
            tick();
        end
        set_in(1'b0, 1'b0, 28'h0);
        out_ready = 1'b0;
        rsp_done  = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
